// File: rtl/ins_pkg.sv
// rtl/ins_pkg.sv - shared constants for the instruction sequencer
package ins_pkg;

  // Default widths: address, instruction word, retired counter
  localparam int AW_DEF = 12;
  localparam int IW_DEF = 16;
  localparam int RW_DEF = 16;

  // Field extraction: opcode is the top OPW bits, TSTF selects one of STATUS_W bits
  localparam int OPW      = 4;
  localparam int STATUS_W = 16;
  localparam int TST_SELW = 4;

  // Opcodes
  localparam logic [OPW-1:0] OP_NOP  = 4'd0;
  localparam logic [OPW-1:0] OP_JMP  = 4'd1;
  localparam logic [OPW-1:0] OP_BF   = 4'd2;
  localparam logic [OPW-1:0] OP_SETF = 4'd3;
  localparam logic [OPW-1:0] OP_TSTF = 4'd4;
  localparam logic [OPW-1:0] OP_LDC  = 4'd5;
  localparam logic [OPW-1:0] OP_DJNZ = 4'd6;
  localparam logic [OPW-1:0] OP_HALT = 4'd15;

  // Sequencer states
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/ins_decode.sv
// rtl/ins_decode.sv - combinational decode of the held instruction word
module ins_decode
  import ins_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [IW-1:0] ir,
  input  logic          irValid,
  input  logic          flag,
  input  logic [AW-1:0] loopCnt,
  output logic          conditional,
  output logic          unConditional,
  output logic [AW-1:0] inData,
  output logic          flagWe,
  output logic          flagTst,
  output logic          loopWe,
  output logic          loopLoad,
  output logic          isHalt
);

  logic [OPW-1:0] op;
  logic [AW-1:0]  imm;

  assign op  = ir[IW-1 -: OPW];
  assign imm = ir[AW-1:0];

  // Relative jumps hand the counter imm-1 because it adds before its own increment
  always_comb begin
    conditional   = 1'b0;
    unConditional = 1'b0;
    inData        = '0;
    flagWe        = 1'b0;
    flagTst       = 1'b0;
    loopWe        = 1'b0;
    loopLoad      = 1'b0;
    isHalt        = 1'b0;
    if (irValid) begin
      case (op)
        OP_NOP: ;
        OP_JMP: begin
          unConditional = 1'b1;
          inData        = imm;
        end
        OP_BF: begin
          if (flag) begin
            conditional = 1'b1;
            inData      = imm - AW'(1);
          end
        end
        OP_SETF: flagWe = 1'b1;
        OP_TSTF: begin
          flagWe  = 1'b1;
          flagTst = 1'b1;
        end
        OP_LDC: begin
          loopWe   = 1'b1;
          loopLoad = 1'b1;
        end
        OP_DJNZ: begin
          loopWe = 1'b1;
          if (loopCnt != AW'(1)) begin
            conditional = 1'b1;
            inData      = imm - AW'(1);
          end
        end
        OP_HALT: isHalt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ins_sequencer.sv
// rtl/ins_sequencer.sv - fetch/decode sequencer driving the program counter
module ins_sequencer
  import ins_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       insAd,
  input  logic [IW-1:0]       insData,
  input  logic [STATUS_W-1:0] statusIn,
  output logic                conditional,
  output logic                unConditional,
  output logic [AW-1:0]       inData,
  output logic                stop,
  output logic [RW-1:0]       retCnt
);

  logic [IW-1:0] ir;
  logic [AW-1:0] irAd;
  logic          irValid;
  logic          flag;
  logic [AW-1:0] loopCnt;
  logic [1:0]    state;

  logic flagWe, flagTst, loopWe, loopLoad, isHalt;

  ins_decode #(.AW(AW), .IW(IW)) u_decode (
    .ir           (ir),
    .irValid      (irValid),
    .flag         (flag),
    .loopCnt      (loopCnt),
    .conditional  (conditional),
    .unConditional(unConditional),
    .inData       (inData),
    .flagWe       (flagWe),
    .flagTst      (flagTst),
    .loopWe       (loopWe),
    .loopLoad     (loopLoad),
    .isHalt       (isHalt)
  );

  // Fetch, execute side effects and RUN/FLUSH/HALT sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir      <= '0;
      irAd    <= '0;
      irValid <= 1'b0;
      flag    <= 1'b0;
      loopCnt <= '0;
      state   <= ST_RUN;
      stop    <= 1'b0;
      retCnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (irValid) begin
            if (flagWe) flag <= flagTst ? statusIn[ir[TST_SELW-1:0]] : ir[0];
            if (loopWe) loopCnt <= loopLoad ? ir[AW-1:0] : loopCnt - AW'(1);
            if (retCnt != '1) retCnt <= retCnt + RW'(1);
          end
          if (isHalt) begin
            // IR stays frozen on the halting word
            state   <= ST_HALT;
            stop    <= 1'b1;
            irValid <= 1'b0;
          end else begin
            ir   <= insData;
            irAd <= insAd;
            if (conditional || unConditional) begin
              // Word arriving with the jump is from the old path: load it as a bubble
              state   <= ST_FLUSH;
              irValid <= 1'b0;
            end else begin
              irValid <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          ir      <= insData;
          irAd    <= insAd;
          irValid <= 1'b1;
          state   <= ST_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_sequencer.sv
// tb/tb_ins_sequencer.sv - directed bench for ins_sequencer with a counter model
module tb_ins_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] insAd;
  logic [15:0] insData;
  logic [15:0] statusIn = 16'h0;
  logic        conditional, unConditional, stop;
  logic [11:0] inData;
  logic [15:0] retCnt;

  logic [15:0] rom [0:4095];
  logic [11:0] pc = 12'h0;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] status;
    logic        cnd;
    logic        unc;
    logic [11:0] ind;
    logic        flg;
    logic [11:0] lc;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  ins_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .insAd        (insAd),
    .insData      (insData),
    .statusIn     (statusIn),
    .conditional  (conditional),
    .unConditional(unConditional),
    .inData       (inData),
    .stop         (stop),
    .retCnt       (retCnt)
  );

  always #5 clk = ~clk;

  assign insAd   = pc;
  assign insData = rom[insAd];

  // Program counter: samples the sequencer requests on the falling edge
  always @(negedge clk) begin
    if (reset) pc <= 12'h0;
    else if (!stop) begin
      if (unConditional) pc <= inData - 12'd1;
      else if (conditional) pc <= pc + inData;
      else pc <= pc + 12'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   taken;

    vt[0]  = '{16'h0000, 16'h1010, 16'h0000, 1'b0, 1'b1, 12'h010, 1'b0, 12'h000};
    vt[1]  = '{16'h3001, 16'h2FFE, 16'h0000, 1'b1, 1'b0, 12'hFFD, 1'b1, 12'h000};
    vt[2]  = '{16'h3000, 16'h2FFE, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000};
    vt[3]  = '{16'h5003, 16'h6FFF, 16'h0000, 1'b1, 1'b0, 12'hFFE, 1'b0, 12'h002};
    vt[4]  = '{16'h5001, 16'h6FFF, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000};
    vt[5]  = '{16'h5000, 16'h6FFF, 16'h0000, 1'b1, 1'b0, 12'hFFE, 1'b0, 12'hFFF};
    vt[6]  = '{16'h4007, 16'h2003, 16'h0080, 1'b1, 1'b0, 12'h002, 1'b1, 12'h000};
    vt[7]  = '{16'h4006, 16'h2003, 16'h0080, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000};
    vt[8]  = '{16'h0000, 16'h7123, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000};
    vt[9]  = '{16'h3001, 16'hF000, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000};
    vt[10] = '{16'h3001, 16'h2000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 1'b1, 12'h000};

    clear_rom();

    // Reset state
    step();
    check("rst cond", conditional, 0);
    check("rst uncond", unConditional, 0);
    check("rst inData", inData, 0);
    check("rst stop", stop, 0);
    check("rst retCnt", retCnt, 0);
    check("rst irValid", dut.irValid, 0);

    // Two-word programs: w0 sets up, w1 is decoded and then executed
    for (int i = 0; i < NV; i++) begin
      rom[0]   = vt[i].w0;
      rom[1]   = vt[i].w1;
      statusIn = vt[i].status;
      do_reset();
      step();
      step();
      check($sformatf("v%0d cond", i), conditional, vt[i].cnd);
      check($sformatf("v%0d uncond", i), unConditional, vt[i].unc);
      check($sformatf("v%0d inData", i), inData, vt[i].ind);
      step();
      check($sformatf("v%0d flag", i), dut.flag, vt[i].flg);
      check($sformatf("v%0d loopCnt", i), dut.loopCnt, vt[i].lc);
      check($sformatf("v%0d retCnt", i), retCnt, 2);
    end
    statusIn = 16'h0;

    // JMP 0x010 with a JMP sitting in the flushed slot
    clear_rom();
    rom[0]     = 16'h1010;
    rom[12'h00F] = 16'h1000;
    do_reset();
    step();
    check("jmp uncond", unConditional, 1);
    check("jmp inData", inData, 12'h010);
    step();
    check("jmp bubble uncond", unConditional, 0);
    check("jmp bubble valid", dut.irValid, 0);
    step();
    check("jmp target valid", dut.irValid, 1);
    check("jmp target irAd", dut.irAd, 12'h010);
    step();
    check("jmp retCnt", retCnt, 2);

    // SETF 1 / BF -2 at 5,6: lands on 4 after one bubble
    clear_rom();
    rom[5] = 16'h3001;
    rom[6] = 16'h2FFE;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (conditional) found = 1'b1;
    end
    check("bf taken seen", found, 1);
    check("bf inData", inData, 12'hFFD);
    check("bf irAd", dut.irAd, 12'h006);
    step();
    check("bf bubble", dut.irValid, 0);
    step();
    check("bf land valid", dut.irValid, 1);
    check("bf land irAd", dut.irAd, 12'h004);

    // SETF 0 / BF: falls through with no bubble
    rom[5] = 16'h3000;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (dut.irValid && dut.irAd == 12'h006) found = 1'b1;
    end
    check("bfnt reached", found, 1);
    check("bfnt cond", conditional, 0);
    step();
    check("bfnt next valid", dut.irValid, 1);
    check("bfnt next irAd", dut.irAd, 12'h007);

    // LDC 3 / NOP / DJNZ -1 / HALT: two taken passes then fall through
    clear_rom();
    rom[0] = 16'h5003;
    rom[2] = 16'h6FFF;
    rom[3] = 16'hF000;
    do_reset();
    taken = 0;
    for (int k = 0; k < 100 && !stop; k++) begin
      step();
      if (conditional) taken++;
    end
    check("djnz halted", stop, 1);
    check("djnz taken", taken, 2);
    check("djnz loopCnt", dut.loopCnt, 12'h000);
    check("djnz retCnt", retCnt, 8);

    // HALT at 2 with a JMP behind it
    clear_rom();
    rom[2] = 16'hF000;
    rom[3] = 16'h1000;
    do_reset();
    step();
    step();
    step();
    check("halt pre stop", stop, 0);
    step();
    check("halt stop", stop, 1);
    check("halt retCnt", retCnt, 3);
    for (int k = 0; k < 5; k++) step();
    check("halt stop held", stop, 1);
    check("halt retCnt held", retCnt, 3);
    check("halt uncond", unConditional, 0);
    check("halt cond", conditional, 0);
    check("halt ir frozen", dut.ir, 16'hF000);
    #2 reset = 1'b1;
    #1;
    check("halt async stop", stop, 0);
    check("halt async retCnt", retCnt, 0);
    @(negedge clk);
    #1 reset = 1'b0;

    // Reset asserted while a JMP is being decoded
    clear_rom();
    rom[0] = 16'h1010;
    do_reset();
    step();
    check("mid uncond before", unConditional, 1);
    #2 reset = 1'b1;
    #1;
    check("mid async uncond", unConditional, 0);
    check("mid async inData", inData, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    check("mid first fetch valid", dut.irValid, 1);
    check("mid retCnt", retCnt, 0);
    check("mid refetch uncond", unConditional, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ins_sequencer.md
Name: ins_sequencer

Overview:
- Fetch/decode companion to the program counter.
- Samples the instruction word returned for the current instruction address and decodes it one cycle later.
- Drives the counter's control inputs back to it: conditional, unConditional, inData and stop.
- Owns the branch flag, the loop counter, the halt latch and a retired-instruction count.
- Sits between the counter, the instruction ROM (combinational read) and the status bus.

Parameters:
- AW, 12, instruction address width; must match insAd.
- IW, 16, instruction width: opcode in [IW-1:IW-4], immediate in [AW-1:0].
- RW, 16, retired-count width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- insAd  in  AW  current instruction address from the program counter.
- insData  in  IW  ROM word at insAd, valid before each rising edge.
- statusIn  in  16  external status bits tested by TSTF.
- conditional  out  1  relative jump request, held for the whole decode cycle.
- unConditional  out  1  absolute jump request, held for the whole decode cycle.
- inData  out  AW  jump operand.
- stop  out  1  halt request; sticky until reset.
- retCnt  out  RW  count of executed (non-flushed) instructions.

Behaviour:
- Reset values: IR=0, irAd=0, irValid=0, flag=0, loopCnt=0, state=RUN, retCnt=0. All outputs are 0 during and after reset.
- Fetch: each rising edge in state RUN loads IR<=insData and irAd<=insAd.
  - irValid<=1 in RUN.
  - irValid<=0 when the edge ends a taken-jump cycle.
- Decode/execute: happens in the cycle after fetch, using IR only when irValid=1.
  - All outputs are functions of registers only, so they are stable before the counter's falling-edge sampling.
- Opcodes:
  - 0 NOP: no effect.
  - 1 JMP: unConditional=1, inData=imm. Counter lands on imm.
  - 2 BF: if flag=1, conditional=1, inData=imm-1 (mod 2^AW). Counter lands on irAd+imm (mod 2^AW); imm is two's-complement.
  - 3 SETF: flag<=imm[0].
  - 4 TSTF: flag<=statusIn[imm[3:0]].
  - 5 LDC: loopCnt<=imm.
  - 6 DJNZ: loopCnt<=loopCnt-1. Taken (relative, as BF) iff loopCnt!=1. loopCnt=0 wraps to all-ones and is taken.
  - 15 HALT: stop<=1 on the next edge, state<=HALT.
  - Others: treated as NOP and still retired.
- Taken jump: on the closing edge, state goes RUN->FLUSH. The word captured on that edge is rom[target-1] and is loaded with irValid=0. On the next edge state returns to RUN and the target word is fetched. Cost: exactly one bubble cycle per taken jump.
- HALT state:
  - IR frozen, irValid=0, jump outputs 0, stop=1.
  - Exit only by reset.
- Flushed or invalid slots do not change flag, loopCnt, retCnt or stop.
- retCnt increments once per valid executed instruction, including HALT and untaken branches. It saturates at all-ones.
- Not-taken BF/DJNZ: no bubble.
- Back-to-back jumps: the second jump is always in the flushed slot and is ignored.
- Reset asserted mid-jump or in HALT: outputs drop to 0 asynchronously. The first edge after release fetches with irValid=1.

Decomposition:
- Package ins_pkg:
  - Opcode constants OP_NOP..OP_HALT.
  - AW/IW defaults.
  - State encoding RUN/FLUSH/HALT.
  - Field-extraction widths.
- One combinational sub-module, ins_decode: takes IR, irValid, flag and loopCnt; produces conditional, unConditional, inData, the flag/loopCnt next-value enables and isHalt.
- ins_sequencer holds the registers and the FSM.

Test Plan:
- Reset mid-run with IR=JMP → all outputs 0 immediately. After release: retCnt=0, first fetch valid.
- ROM[0]=JMP 0x010, ROM[0x010]=NOP → unConditional=1 and inData=0x010 for one cycle. Next IR valid with irAd=0x010. One flushed slot; retCnt=2.
- ROM[5]=SETF 1, ROM[6]=BF 0xFFE (offset -2) → conditional=1 with inData=0xFFD. Counter lands on 4.
  - Repeat with SETF 0 → no jump, no bubble.
- LDC 3 then DJNZ -1 looping → taken twice, falls through on the third pass, loopCnt=0. Repeat with LDC 0 → taken; loopCnt=0xFFF.
- statusIn=0x0080, TSTF 7 then BF → taken. TSTF 6 → not taken.
- ROM[2]=HALT → stop=1 from the next edge and stays 1. retCnt frozen at 3. IR contents ignored until reset clears stop.
